// File: rtl/bpb_pkg.sv
// Shared branch-predictor types and constants used by the table update path.
package bpb_pkg;
  // Default table index width; table size is 2**BPB_T_DEF entries.
  localparam int BPB_T_DEF = 4;

  typedef logic [31:0]          Word;
  typedef logic [BPB_T_DEF-1:0] Index;

  typedef struct packed {
    Word  pc;
    logic taken;
  } UpdEntry;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } UpdState;

  // Counter value written by a clear (weakly not-taken).
  localparam logic [1:0] CNT_INIT = 2'b01;
endpackage

// File: rtl/bpb_fifo.sv
// Circular FIFO of branch resolutions; pointers carry a wrap bit to tell full from empty.
module bpb_fifo
  import bpb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    clear,
  input  logic    push,
  input  UpdEntry din,
  input  logic    pop,
  output UpdEntry dout,
  output logic    empty,
  output logic    full
);
  localparam int AW = $clog2(DEPTH);

  UpdEntry        mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clear) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/bpb_update_ctrl.sv
// Predictor table update sequencer: clears every index after reset/flush, then
// drains queued branch resolutions into the single table write port.
module bpb_update_ctrl
  import bpb_pkg::*;
#(
  parameter int BPB_T = BPB_T_DEF,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [31:0]      res_pc,
  input  logic             res_taken,
  input  logic             res_miss,
  output logic             wr_en,
  output logic             wr_clear,
  output logic [BPB_T-1:0] wr_index,
  output logic             wr_taken,
  output logic             pred_en,
  output logic             busy,
  output logic [15:0]      miss_count
);
  // Handshake: a resolution transfers on a clock edge where res_valid && res_ready;
  // res_ready never depends on res_valid.

  UpdState          state, state_nxt;
  logic [BPB_T-1:0] sweep_idx, sweep_nxt;
  UpdEntry          head, din;
  logic             fifo_empty, fifo_full;
  logic             push, pop;
  logic             unused_pc;

  assign din       = '{pc: res_pc, taken: res_taken};
  assign res_ready = reset && !fifo_full && !flush;
  assign push      = res_valid && res_ready;
  assign pop       = (state == RUN) && !fifo_empty;
  assign unused_pc = ^{head.pc[31:BPB_T+2], head.pc[1:0]};

  assign pred_en = (state == RUN);
  assign busy    = (state == SWEEP);

  bpb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SWEEP;
      sweep_idx <= '0;
    end else begin
      state     <= state_nxt;
      sweep_idx <= sweep_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep_idx;
    wr_en     = 1'b0;
    wr_clear  = 1'b0;
    wr_index  = '0;
    wr_taken  = 1'b0;
    if (flush) begin
      state_nxt = SWEEP;
      sweep_nxt = '0;
    end else if (state == SWEEP) begin
      sweep_nxt = sweep_idx + 1'b1;
      if (sweep_idx == '1) state_nxt = RUN;
    end
    // Outputs are gated by reset so nothing is written while reset is held.
    if (reset) begin
      if (state == SWEEP) begin
        wr_en    = 1'b1;
        wr_clear = 1'b1;
        wr_index = sweep_idx;
      end else if (!fifo_empty) begin
        wr_en    = 1'b1;
        wr_index = head.pc[BPB_T+1:2];
        wr_taken = head.taken;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miss_count <= '0;
    end else if (push && res_miss && (miss_count != 16'hFFFF)) begin
      miss_count <= miss_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_bpb_update_ctrl.sv
// Randomized bench for bpb_update_ctrl against a queue-based model of the update rules.
module tb_bpb_update_ctrl;
  localparam int BPB_T = 4;
  localparam int DEPTH = 4;
  localparam int TBL   = 1 << BPB_T;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_pc;
  logic             res_taken;
  logic             res_miss;
  logic             wr_en;
  logic             wr_clear;
  logic [BPB_T-1:0] wr_index;
  logic             wr_taken;
  logic             pred_en;
  logic             busy;
  logic [15:0]      miss_count;

  bpb_update_ctrl #(.BPB_T(BPB_T), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_pc     (res_pc),
    .res_taken  (res_taken),
    .res_miss   (res_miss),
    .wr_en      (wr_en),
    .wr_clear   (wr_clear),
    .wr_index   (wr_index),
    .wr_taken   (wr_taken),
    .pred_en    (pred_en),
    .busy       (busy),
    .miss_count (miss_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int          checks = 0;
  int          errors = 0;
  int          sweep_pos;          // cycles of clearing done since the last sweep began
  logic [32:0] exp_q[$];           // accepted {pc, taken} not yet written
  int          exp_miss;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sweep_pos = 0;
    exp_q.delete();
    exp_miss = 0;
  endtask

  task automatic check_outputs();
    bit          sweeping;
    logic [32:0] hd;
    logic [31:0] e_idx;
    sweeping = (sweep_pos < TBL);
    hd       = (exp_q.size() > 0) ? exp_q[0] : 33'd0;
    if (sweeping)              e_idx = sweep_pos;
    else if (exp_q.size() > 0) e_idx = (hd[32:1] >> 2) % TBL;
    else                       e_idx = 0;
    check("wr_en",      wr_en,      sweeping || exp_q.size() > 0);
    check("wr_clear",   wr_clear,   sweeping);
    check("wr_index",   wr_index,   e_idx);
    check("wr_taken",   wr_taken,   !sweeping && exp_q.size() > 0 && hd[0]);
    check("res_ready",  res_ready,  exp_q.size() < DEPTH && !flush);
    check("pred_en",    pred_en,    !sweeping);
    check("busy",       busy,       sweeping);
    check("miss_count", miss_count, exp_miss);
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; drives inputs, checks at negedge, advances model at the edge.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic tk,
                       input logic ms, input logic fl, output bit acc);
    res_valid = v; res_pc = pc; res_taken = tk; res_miss = ms; flush = fl;
    @(negedge clk);
    check_outputs();
    acc = v && (exp_q.size() < DEPTH) && !fl;
    @(posedge clk);
    if (fl) begin
      sweep_pos = 0;
      exp_q.delete();
    end else begin
      if (sweep_pos < TBL)       sweep_pos++;
      else if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({pc, tk});
    end
    if (acc && ms && exp_miss < 65535) exp_miss++;
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  task automatic rand_cycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++)
      cycle($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 99) < 2, acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},     wr_en,      1'b0);
    check({tag, "_wr_clear"},  wr_clear,   1'b0);
    check({tag, "_wr_taken"},  wr_taken,   1'b0);
    check({tag, "_wr_index"},  wr_index,   0);
    check({tag, "_res_ready"}, res_ready,  1'b0);
    check({tag, "_busy"},      busy,       1'b1);
    check({tag, "_pred_en"},   pred_en,    1'b0);
    check({tag, "_miss"},      miss_count, 0);
  endtask

  // Entered at posedge+1 with reset low; releases it so the next cycle is sweep index 0.
  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          acc;
    int          n_acc;
    int          c;
    int          fifth_cycle;
    logic [31:0] pcs [5];

    reset = 1'b0; flush = 1'b0; res_valid = 1'b0;
    res_pc = '0; res_taken = 1'b0; res_miss = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    release_reset();

    // Reset sweep plus backpressure: five resolutions offered from sweep start.
    pcs[0] = 32'h40; pcs[1] = 32'h44; pcs[2] = 32'h48; pcs[3] = 32'h4C; pcs[4] = 32'h50;
    n_acc = 0; c = 0; fifth_cycle = -1;
    while (n_acc < 5 && c < 40) begin
      cycle(1'b1, pcs[n_acc], n_acc[0], 1'b0, 1'b0, acc);
      if (acc) begin
        if (n_acc == 4) fifth_cycle = c;
        n_acc++;
      end
      c++;
    end
    check("fifth_accept_cycle", fifth_cycle, 17);
    idle(6);
    check("drained_wr_en", wr_en, 1'b0);

    // Single update in RUN.
    cycle(1'b1, 32'h1008, 1'b1, 1'b0, 1'b0, acc);
    res_valid = 1'b0;
    #3;
    check("single_wr_en",    wr_en,    1'b1);
    check("single_wr_index", wr_index, 2);
    check("single_wr_taken", wr_taken, 1'b1);
    idle(2);

    rand_cycles(300);

    // Flush mid-sweep with two queued entries.
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
    cycle(1'b1, 32'h0000_0124, 1'b1, 1'b1, 1'b0, acc);
    cycle(1'b1, 32'h0000_0138, 1'b0, 1'b0, 1'b0, acc);
    idle(5);
    check("flush_at_idx7", wr_index, 7);
    cycle(1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b1, acc);
    check("flush_rejected", acc, 1'b0);
    idle(TBL + 3);
    check("flush_no_stale", wr_en, 1'b0);

    // Held flush keeps the sweep pinned at index 0.
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b1, acc);
    idle(TBL + 1);

    rand_cycles(300);

    // Miss counter saturation.
    idle(TBL + DEPTH + 2);
    for (int i = 0; i < 65537; i++) cycle(1'b1, $urandom, $urandom_range(0, 1), 1'b1, 1'b0, acc);
    check("miss_sat", miss_count, 16'hFFFF);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
    idle(TBL + 1);
    check("miss_after_flush", miss_count, 16'hFFFF);

    // Reset mid-drain: three entries queued when RUN begins.
    reset = 1'b0; #2; check_reset_outputs("rst2");
    release_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h100 + 32'(i * 4), 1'b1, 1'b0, 1'b0, acc);
    idle(TBL - 3);
    check("drain_queued", exp_q.size(), 3);
    check("drain_wr_en", wr_en, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    release_reset();
    idle(TBL + 3);
    check("after_mid_reset", wr_en, 1'b0);

    rand_cycles(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end
endmodule
